instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Per-core instruction fetch unit. It reads the PC that the branch/PC unit commits and returns the 16-bit instruction word at that address. It runs a valid/ready read handshake with the program-memory controller and holds the fetched word stable for the decoder. A single-entry reuse buffer skips the memory round trip when the same PC is fetched again, for example a branch-to-self spin loop.

## Interface
Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, program-memory address width; equals PC width.
- PROGRAM_MEM_DATA_BITS, 16, instruction word width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- core_state  in  3  core scheduler state: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch; stable while core_state=FETCH.
- flush  in  1  one-cycle pulse at kernel start; invalidates the reuse buffer.
- mem_read_valid  out  1  read request to program memory.
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address.
- mem_read_ready  in  1  memory response valid; completes the request.
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  response data, valid when mem_read_ready=1.
- fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010.
- instruction  out  PROGRAM_MEM_DATA_BITS  last fetched instruction word.

## Operation
- All outputs are registered.
- Internal state: buf_pc (ADDR_BITS), buf_valid (1).
- IDLE:
  - If core_state=FETCH and buf_valid=1 and buf_pc=current_pc (hit): go to FETCHED. instruction is unchanged, no memory request.
  - If core_state=FETCH and miss: mem_read_valid<=1, mem_read_address<=current_pc, go to FETCHING.
  - Otherwise: stay in IDLE.
- FETCHING:
  - Hold mem_read_valid=1 and the address constant until mem_read_ready=1.
  - On mem_read_ready=1: instruction<=mem_read_data, mem_read_valid<=0, buf_pc<=mem_read_address, buf_valid<=1, go to FETCHED.
  - mem_read_ready while in IDLE or FETCHED is ignored.
- FETCHED:
  - Hold instruction.
  - When core_state=DECODE: go to IDLE.
  - Any other core_state: remain in FETCHED.
- flush:
  - Clears buf_valid on the next edge in any state.
  - If flush coincides with a completing fill, flush wins: buf_valid=0. instruction is still updated.
  - flush does not abort an in-flight request.
- Encodings 011–111 of fetcher_state are never produced.

## Timing
- Reset values: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, buf_valid=0, buf_pc=0.
- Miss latency:
  - Edge E0 samples core_state=FETCH in IDLE.
  - From E0, mem_read_valid=1 and fetcher_state=FETCHING.
  - If memory asserts ready in cycle k after E0, then from the following edge instruction is valid, fetcher_state=FETCHED and mem_read_valid=0.
  - Minimum is 2 edges from FETCH detection to FETCHED.
- Hit latency: 1 edge from FETCH detection to FETCHED. mem_read_valid stays 0 throughout.
- No combinational path from any input to any output.
- Reset mid-request: the request is dropped immediately; mem_read_valid=0 after the reset edge. The memory controller tolerates a withdrawn request. A late mem_read_ready is ignored because the unit is then in IDLE.
- Only one outstanding request ever exists.

## Test plan
- Reset, then core_state=FETCH, current_pc=0x05, memory returns 0x3A7F after 3 cycles -> mem_read_valid=1 and address=0x05 for exactly 3 cycles; then instruction=0x3A7F, fetcher_state=FETCHED, mem_read_valid=0.
- After the above, core_state=DECODE -> IDLE. Then FETCH with current_pc=0x05 again -> FETCHED one edge later, instruction=0x3A7F, mem_read_valid never asserted.
- Same sequence with a flush pulse between the fetches -> second fetch misses, re-issues address 0x05.
- Refetch with current_pc=0x06 -> miss, new request to 0x06, buf_pc becomes 0x06.
- Stall: FETCHED held while core_state=FETCH for 4 cycles -> state, instruction and mem_read_valid=0 unchanged until DECODE.
- Reset asserted during FETCHING, then mem_read_ready pulses -> outputs at reset values, instruction stays 0, state IDLE.

Source files
------------

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - instruction fetch unit with single-entry PC reuse buffer
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } fetch_state_e;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  fetch_state_e                     state_q;
  logic                             mem_read_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_pc_q;
  logic                             buf_valid_q;
  logic                             buf_valid_d;
  logic                             buf_hit;
  logic                             fill_done;

  // A hit needs a valid buffer tagged with the PC being fetched.
  assign buf_hit   = buf_valid_q && (buf_pc_q == current_pc);
  // A fill completes only while a request is outstanding; stray ready pulses are ignored.
  assign fill_done = (state_q == S_FETCHING) && mem_read_ready;

  // Buffer valid next state: a completing fill sets it, flush clears it and wins.
  always_comb begin
    buf_valid_d = buf_valid_q;
    if (fill_done) buf_valid_d = 1'b1;
    if (flush)     buf_valid_d = 1'b0;
  end

  // Reuse buffer registers; the tag is the address of the request that just completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      if (fill_done) buf_pc_q <= mem_read_address_q;
    end
  end

  // Fetch FSM with registered request and instruction outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      instruction_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (buf_hit) begin
              state_q <= S_FETCHED;
            end else begin
              mem_read_valid_q   <= 1'b1;
              mem_read_address_q <= current_pc;
              state_q            <= S_FETCHING;
            end
          end
        end
        S_FETCHING: begin
          if (mem_read_ready) begin
            instruction_q    <= mem_read_data;
            mem_read_valid_q <= 1'b0;
            state_q          <= S_FETCHED;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= S_IDLE;
        end
        default: begin
          state_q          <= S_IDLE;
          mem_read_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = mem_read_address_q;
  assign instruction      = instruction_q;
  assign fetcher_state    = state_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - randomized self-checking bench for instruction_fetcher
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_IDLE = 3'd0, C_FETCH = 3'd1, C_DECODE = 3'd2;
  localparam logic [2:0] F_IDLE = 3'd0, F_FETCHING = 3'd1, F_FETCHED = 3'd2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: program memory contents and what the reuse buffer should hold.
  logic [15:0] mem [256];
  logic        m_valid;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 8'h00;
    m_instr = 16'h0000;
  endtask

  // One fetch: hit or miss decided from the model, memory answers lat cycles after detection.
  task automatic do_fetch(input logic [7:0] pc, input int lat, input bit flush_mid, input bit flush_fill);
    bit hit;
    int valid_cycles;
    hit = m_valid && (m_pc == pc);
    core_state = C_FETCH;
    current_pc = pc;
    tick();
    if (hit) begin
      check("hit_state", fetcher_state, F_FETCHED);
      check("hit_req", mem_read_valid, 0);
      check("hit_instr", instruction, m_instr);
    end else begin
      valid_cycles = 0;
      check("miss_state", fetcher_state, F_FETCHING);
      check("miss_addr", mem_read_address, pc);
      if (mem_read_valid) valid_cycles++;
      for (int i = 1; i < lat; i++) begin
        flush = flush_mid && (i == 1);
        tick();
        flush = 1'b0;
        check("wait_state", fetcher_state, F_FETCHING);
        check("wait_addr", mem_read_address, pc);
        if (mem_read_valid) valid_cycles++;
      end
      check("req_cycles", valid_cycles, lat);
      mem_read_ready = 1'b1;
      mem_read_data  = mem[pc];
      flush          = flush_fill;
      tick();
      mem_read_ready = 1'b0;
      flush          = 1'b0;
      mem_read_data  = 16'($urandom);
      m_instr = mem[pc];
      m_pc    = pc;
      m_valid = !flush_fill;
      check("fill_state", fetcher_state, F_FETCHED);
      check("fill_req", mem_read_valid, 0);
      check("fill_instr", instruction, m_instr);
    end
  endtask

  // Stall in FETCHED for n cycles with noise on ready/data, then DECODE releases to IDLE.
  task automatic hold_and_decode(input int n, input int flush_at);
    int v;
    for (int i = 0; i < n; i++) begin
      v = $urandom_range(0, 6);
      if (v >= 2) v++;
      core_state     = 3'(v);
      mem_read_ready = 1'($urandom);
      mem_read_data  = 16'($urandom);
      flush          = (i == flush_at);
      tick();
      if (flush) m_valid = 1'b0;
      flush = 1'b0;
      check("hold_state", fetcher_state, F_FETCHED);
      check("hold_req", mem_read_valid, 0);
      check("hold_instr", instruction, m_instr);
    end
    mem_read_ready = 1'b0;
    core_state     = C_DECODE;
    tick();
    check("decode_state", fetcher_state, F_IDLE);
    check("decode_req", mem_read_valid, 0);
    core_state = C_IDLE;
  endtask

  task automatic pulse_flush();
    core_state = C_IDLE;
    flush      = 1'b1;
    tick();
    flush   = 1'b0;
    m_valid = 1'b0;
    check("flush_state", fetcher_state, F_IDLE);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'h3A7F;
    reset = 1'b1; core_state = C_IDLE; current_pc = 8'h00; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check("rst_state", fetcher_state, F_IDLE);
    check("rst_req", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_instr", instruction, 0);

    // Directed sequence.
    do_fetch(8'h05, 3, 1'b0, 1'b0);
    check("dir_instr", instruction, 16'h3A7F);
    hold_and_decode(4, -1);
    do_fetch(8'h05, 3, 1'b0, 1'b0);   // hit
    hold_and_decode(1, -1);
    pulse_flush();
    do_fetch(8'h05, 2, 1'b0, 1'b0);   // miss after flush
    hold_and_decode(0, -1);
    do_fetch(8'h06, 1, 1'b0, 1'b0);   // new PC, minimum latency
    hold_and_decode(2, -1);
    do_fetch(8'h06, 4, 1'b0, 1'b0);   // hit on 0x06 proves tag moved
    hold_and_decode(0, -1);
    do_fetch(8'h07, 2, 1'b0, 1'b1);   // flush coinciding with fill
    hold_and_decode(0, -1);
    do_fetch(8'h07, 2, 1'b0, 1'b0);   // must miss again
    hold_and_decode(0, -1);

    // Randomized transactions over a small PC set to produce frequent hits.
    for (int t = 0; t < 60; t++) begin
      logic [7:0] pc;
      int lat;
      bit fm, ff;
      pc  = 8'($urandom_range(0, 3)) + 8'h10;
      lat = $urandom_range(1, 5);
      fm  = ($urandom_range(0, 4) == 0) && (lat >= 2);
      ff  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) pulse_flush();
      do_fetch(pc, lat, fm, ff);
      hold_and_decode($urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? 0 : -1);
    end

    // Reset while a request is outstanding; late ready pulses must be ignored.
    core_state = C_FETCH;
    current_pc = m_pc ^ 8'h80;
    tick();
    check("rstreq_state", fetcher_state, F_FETCHING);
    check("rstreq_req", mem_read_valid, 1);
    reset      = 1'b1;
    core_state = C_IDLE;
    tick();
    reset = 1'b0;
    model_reset();
    check("midrst_state", fetcher_state, F_IDLE);
    check("midrst_req", mem_read_valid, 0);
    check("midrst_addr", mem_read_address, 0);
    check("midrst_instr", instruction, 0);
    for (int i = 0; i < 3; i++) begin
      mem_read_ready = 1'b1;
      mem_read_data  = 16'($urandom);
      tick();
      check("late_state", fetcher_state, F_IDLE);
      check("late_instr", instruction, 0);
      check("late_req", mem_read_valid, 0);
    end
    mem_read_ready = 1'b0;
    do_fetch(8'h00, 2, 1'b0, 1'b0);   // buffer invalid after reset, so PC 0 misses
    hold_and_decode(1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
